// File: rtl/div_unit_if.sv
// Request/response bundle between the EX-stage issue logic and the iterative divider.
// The slave modport is the divider side; the master modport is the pipeline side.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            stallreq_o;
  logic            busy_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    output stallreq_o, busy_o, result_valid_o, result_o, rd_addr_o
  );

  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    input  stallreq_o, busy_o, result_valid_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; one quotient bit per cycle,
// with a single-cycle path for divide-by-zero and signed overflow.
module div_unit #(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  div_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d, rdOut_q, rdOut_d;
  logic            negQ_q, negQ_d, negR_q, negR_d;

  logic            isSigned, dividendNeg, divisorNeg, divByZero, overflow, stallReq;
  logic [XLEN-1:0] absDividend, absDivisor, fastQuo, fastRem, fastResult;
  logic [XLEN:0]   remShift, trial;
  logic [XLEN-1:0] remNext, quoNext, quoFinal, remFinal;

  // Operand conditioning, fast-path results and one restoring iteration.
  always_comb begin
    isSigned    = ~bus.op_i[0];
    dividendNeg = isSigned & bus.dividend_i[XLEN-1];
    divisorNeg  = isSigned & bus.divisor_i[XLEN-1];
    absDividend = dividendNeg ? -bus.dividend_i : bus.dividend_i;
    absDivisor  = divisorNeg ? -bus.divisor_i : bus.divisor_i;
    divByZero   = (bus.divisor_i == '0);
    overflow    = isSigned && (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                  && (bus.divisor_i == '1);
    fastQuo     = divByZero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    fastRem     = divByZero ? bus.dividend_i : '0;
    fastResult  = bus.op_i[1] ? fastRem : fastQuo;

    // A 33-bit trial subtract suffices: the shifted remainder is always below 2*divisor.
    remShift = {rem_q, quo_q[XLEN-1]};
    trial    = remShift - {1'b0, dvsr_q};
    remNext  = trial[XLEN] ? remShift[XLEN-1:0] : trial[XLEN-1:0];
    quoNext  = {quo_q[XLEN-2:0], ~trial[XLEN]};
    quoFinal = negQ_q ? -quoNext : quoNext;
    remFinal = negR_q ? -remNext : remNext;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    op_d     = op_q;
    rd_d     = rd_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    result_d = result_q;
    rdOut_d  = rdOut_q;
    stallReq = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          stallReq = 1'b1;
          op_d     = bus.op_i;
          rd_d     = bus.rd_addr_i;
          if (divByZero || overflow) begin
            result_d = fastResult;
            rdOut_d  = bus.rd_addr_i;
            state_d  = DONE;
          end else begin
            quo_d   = absDividend;
            rem_d   = '0;
            dvsr_d  = absDivisor;
            negQ_d  = dividendNeg ^ divisorNeg;
            negR_d  = dividendNeg;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          stallReq = 1'b1;
          rem_d    = remNext;
          quo_d    = quoNext;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            result_d = op_q[1] ? remFinal : quoFinal;
            rdOut_d  = rd_q;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      result_q <= '0;
      rdOut_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      result_q <= result_d;
      rdOut_q  <= rdOut_d;
    end
  end

  assign bus.stallreq_o     = stallReq;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.result_valid_o = (state_q == DONE) && !bus.flush_i;
  assign bus.result_o       = result_q;
  assign bus.rd_addr_o      = rdOut_q;
endmodule
